// File: rtl/fetch_unit.sv
// fetch_unit: SimpleRISC instruction fetch stage; one outstanding imem read,
// IF/OF latch with a one-entry hold buffer for responses that arrive during a stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        isBranchTaken,
    input  logic [31:0] branchPC,
    input  logic        of_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc
);
    typedef enum logic [2:0] {S_RESET, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      state, state_nx;
    logic [31:0] fetch_pc, req_pc, hold_instr, hold_pc;
    logic        ld, grant, load_mem, load_hold, store_hold;

    assign ld         = !if_valid || !of_stall;
    assign grant      = state == S_REQ && imem_gnt;
    assign load_mem   = state == S_WAIT && imem_rvalid && ld && !isBranchTaken;
    assign store_hold = state == S_WAIT && imem_rvalid && !ld && !isBranchTaken;
    assign load_hold  = state == S_HOLD && ld && !isBranchTaken;
    assign imem_req   = state == S_REQ;
    assign imem_addr  = imem_req ? fetch_pc : 32'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_RESET;
        else
            state <= state_nx;
    end

    // Redirect wins over everything; a granted or in-flight read must be drained.
    always_comb begin
        state_nx = state;
        case (state)
            S_RESET: state_nx = S_REQ;
            S_REQ:   state_nx = isBranchTaken ? (imem_gnt ? S_DRAIN : S_REQ)
                              : (imem_gnt ? S_WAIT : S_REQ);
            S_WAIT:  state_nx = isBranchTaken ? (imem_rvalid ? S_REQ : S_DRAIN)
                              : (imem_rvalid ? (ld ? S_REQ : S_HOLD) : S_WAIT);
            S_HOLD:  state_nx = (isBranchTaken || ld) ? S_REQ : S_HOLD;
            S_DRAIN: state_nx = imem_rvalid ? S_REQ : S_DRAIN;
            default: state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc   <= RESET_PC;
            req_pc     <= 32'd0;
            hold_instr <= 32'd0;
            hold_pc    <= 32'd0;
            if_valid   <= 1'b0;
            if_instr   <= 32'd0;
            if_pc      <= 32'd0;
        end else begin
            if (isBranchTaken)
                fetch_pc <= branchPC & ~32'd3;
            else if (grant)
                fetch_pc <= fetch_pc + PC_INC;
            if (grant)
                req_pc <= fetch_pc;
            if (store_hold) begin
                hold_instr <= imem_rdata;
                hold_pc    <= req_pc;
            end
            if (isBranchTaken)
                if_valid <= 1'b0;
            else if (ld)
                if_valid <= load_mem || load_hold;
            if (load_mem) begin
                if_instr <= imem_rdata;
                if_pc    <= req_pc;
            end else if (load_hold) begin
                if_instr <= hold_instr;
                if_pc    <= hold_pc;
            end
        end
    end
endmodule
